// File: rtl/mul_seq_if.sv
// dti valid/ready stream interface carrying a W-bit payload.
// producer/consumer modports are aliased as master/slave.
interface dti #(
  parameter int unsigned W = 8
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport producer (output data, output valid, input  ready);
  modport consumer (input  data, input  valid, output ready);
  modport master   (output data, output valid, input  ready);
  modport slave    (input  data, input  valid, output ready);
endinterface

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier on dti streams; full-width product after TDIN1 cycles.
// Define MUL_SEQ_EARLY_TERM_EN to leave CALC as soon as the remaining multiplier bits are zero.
module mul_seq #(
  parameter int unsigned TDIN0       = 8,
  parameter int unsigned TDIN1       = 8,
  parameter bit          DIN0_SIGNED = 1'b0,
  parameter bit          DIN1_SIGNED = 1'b0
) (
  input  logic clk,
  input  logic rst,
  dti.consumer din0,
  dti.consumer din1,
  dti.producer dout
);
  localparam int unsigned TDOUT = TDIN0 + TDIN1;
  localparam int unsigned TCNT  = $clog2(TDIN1 + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [TDOUT-1:0] mcand;
  logic [TDOUT-1:0] acc;
  logic [TDIN1-1:0] mplier;
  logic [TCNT-1:0]  cnt;
  logic             neg;
  logic             valid_q;
  logic [TDOUT-1:0] data_q;

  logic             take;
  logic             sign_a;
  logic             sign_b;
  logic [TDIN0-1:0] mag_a;
  logic [TDIN1-1:0] mag_b;
  logic [TDOUT-1:0] acc_nxt;
  logic [TDIN1-1:0] mplier_nxt;
  logic [TDOUT-1:0] prod;
  logic             last;

  // Both operands are consumed together, only while idle.
  assign take       = (state == IDLE) & din0.valid & din1.valid;
  assign din0.ready = take;
  assign din1.ready = take;

  // Magnitudes; the most-negative value maps onto 2^(T-1), which still fits unsigned.
  assign sign_a = DIN0_SIGNED & din0.data[TDIN0-1];
  assign sign_b = DIN1_SIGNED & din1.data[TDIN1-1];
  assign mag_a  = sign_a ? (~din0.data + 1'b1) : din0.data;
  assign mag_b  = sign_b ? (~din1.data + 1'b1) : din1.data;

  always_comb begin
    acc_nxt    = acc;
    if (mplier[0]) begin
      acc_nxt = acc + mcand;
    end
    mplier_nxt = mplier >> 1;
    prod       = neg ? (~acc_nxt + 1'b1) : acc_nxt;
`ifdef MUL_SEQ_EARLY_TERM_EN
    last       = (cnt == TCNT'(1)) | (mplier_nxt == '0);
`else
    last       = (cnt == TCNT'(1));
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            mcand  <= TDOUT'(mag_a);
            mplier <= mag_b;
            neg    <= sign_a ^ sign_b;
            acc    <= '0;
            cnt    <= TCNT'(TDIN1);
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier_nxt;
          cnt    <= cnt - 1'b1;
          if (last) begin
            data_q  <= prod;
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (dout.ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dout.valid = valid_q;
  assign dout.data  = data_q;
endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: three instances (unsigned, signed x signed, signed x unsigned) sharing clk/rst.
module tb_mul_seq;
  localparam int unsigned T0 = 8;
  localparam int unsigned T1 = 8;
  localparam int unsigned W  = T0 + T1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0][T0-1:0] a_data;
  logic [2:0][T1-1:0] b_data;
  logic [2:0]         a_valid;
  logic [2:0]         b_valid;
  logic [2:0]         o_ready;
  logic [2:0]         rdy0;
  logic [2:0]         rdy1;
  logic [2:0]         o_valid;
  logic [2:0][W-1:0]  o_data;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dti #(.W(T0)) a_if ();
    dti #(.W(T1)) b_if ();
    dti #(.W(W))  o_if ();
    assign a_if.data  = a_data[g];
    assign a_if.valid = a_valid[g];
    assign b_if.data  = b_data[g];
    assign b_if.valid = b_valid[g];
    assign o_if.ready = o_ready[g];
    assign rdy0[g]    = a_if.ready;
    assign rdy1[g]    = b_if.ready;
    assign o_valid[g] = o_if.valid;
    assign o_data[g]  = o_if.data;
    mul_seq #(
      .TDIN0(T0), .TDIN1(T1),
      .DIN0_SIGNED(g != 0), .DIN1_SIGNED(g == 1)
    ) u_dut (
      .clk(clk), .rst(rst),
      .din0(a_if.consumer), .din1(b_if.consumer), .dout(o_if.producer)
    );
  end

  // Reference product: idx 0 unsigned, 1 signed x signed, 2 signed x unsigned.
  function automatic int val_a(int idx, logic [T0-1:0] a);
    return (idx != 0) ? int'($signed(a)) : int'(a);
  endfunction
  function automatic int val_b(int idx, logic [T1-1:0] b);
    return (idx == 1) ? int'($signed(b)) : int'(b);
  endfunction
  function automatic logic [W-1:0] model(int idx, logic [T0-1:0] a, logic [T1-1:0] b);
    int p;
    p = val_a(idx, a) * val_b(idx, b);
    return W'(p);
  endfunction
  function automatic int exp_lat(int idx, logic [T1-1:0] b);
`ifdef MUL_SEQ_EARLY_TERM_EN
    int m;
    int h;
    m = val_b(idx, b);
    if (m < 0) m = -m;
    h = 0;
    for (int i = 0; i < 9; i++) if (((m >> i) & 1) != 0) h = i;
    return (m == 0) ? 1 : h + 1;
`else
    return int'(T1);
`endif
  endfunction

  task automatic do_op(input int idx, input logic [T0-1:0] a, input logic [T1-1:0] b,
                       input int hold, input bit pend);
    int n;
    logic [W-1:0] got;
    logic [W-1:0] exp;
    a_data[idx] = a; b_data[idx] = b;
    a_valid[idx] = 1'b1; b_valid[idx] = 1'b1;
    @(negedge clk);
    tests++;
    if ({rdy0[idx], rdy1[idx]} !== 2'b11) begin
      fails++; $display("FAIL accept_ready dut%0d got=%b exp=11", idx, {rdy0[idx], rdy1[idx]});
    end
    @(posedge clk); #1;
    exp_q.push_back(model(idx, a, b));
    tests++;
    if ({rdy0[idx], rdy1[idx]} !== 2'b00) begin
      fails++; $display("FAIL ready_pulse dut%0d got=%b exp=00", idx, {rdy0[idx], rdy1[idx]});
    end
    a_valid[idx] = 1'b0; b_valid[idx] = 1'b0;
    n = 0;
    while (o_valid[idx] !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    tests++;
    if (n != exp_lat(idx, b)) begin
      fails++; $display("FAIL latency dut%0d a=%h b=%h got=%0d exp=%0d", idx, a, b, n, exp_lat(idx, b));
    end
    if (o_valid[idx] !== 1'b1) begin
      void'(exp_q.pop_front());
      return;
    end
    got = o_data[idx];
    exp = exp_q.pop_front();
    tests++;
    if (got !== exp) begin
      fails++; $display("FAIL product dut%0d a=%h b=%h got=%h exp=%h", idx, a, b, got, exp);
    end
    if (pend) begin
      a_data[idx] = 8'd3; b_data[idx] = 8'd5;
      a_valid[idx] = 1'b1; b_valid[idx] = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      tests++;
      if (o_valid[idx] !== 1'b1 || o_data[idx] !== got || {rdy0[idx], rdy1[idx]} !== 2'b00) begin
        fails++; $display("FAIL hold dut%0d cyc=%0d valid=%b data=%h rdy=%b exp=1/%h/00",
                          idx, h, o_valid[idx], o_data[idx], {rdy0[idx], rdy1[idx]}, got);
      end
    end
    o_ready[idx] = 1'b1;
    @(negedge clk);
    if (pend) begin
      tests++;
      if ({rdy0[idx], rdy1[idx]} !== 2'b00) begin
        fails++; $display("FAIL pend_handshake_cycle dut%0d rdy=%b exp=00", idx, {rdy0[idx], rdy1[idx]});
      end
    end
    @(posedge clk); #1;
    o_ready[idx] = 1'b0;
    tests++;
    if (o_valid[idx] !== 1'b0) begin
      fails++; $display("FAIL valid_drop dut%0d got=%b exp=0", idx, o_valid[idx]);
    end
    if (pend) begin
      tests++;
      if ({rdy0[idx], rdy1[idx]} !== 2'b11) begin
        fails++; $display("FAIL pend_accept_next dut%0d rdy=%b exp=11", idx, {rdy0[idx], rdy1[idx]});
      end
    end
  endtask

  task automatic test_reset();
    a_valid = '0; b_valid = '0; o_ready = '0; a_data = '0; b_data = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (o_valid !== 3'b000 || o_data !== '0 || rdy0 !== 3'b000 || rdy1 !== 3'b000) begin
      fails++; $display("FAIL reset_state valid=%b data=%h rdy=%b/%b exp=0", o_valid, o_data, rdy0, rdy1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    do_op(0, 8'd255, 8'd255, 0, 1'b0);
    do_op(0, 8'd0, 8'd77, 0, 1'b0);
    do_op(0, 8'd13, 8'd128, 1, 1'b0);
  endtask

  task automatic test_signed();
    do_op(1, 8'h80, 8'h80, 0, 1'b0);
    do_op(1, 8'h7F, 8'h80, 0, 1'b0);
    do_op(1, 8'hFF, 8'h01, 0, 1'b0);
    do_op(1, 8'h05, 8'h00, 0, 1'b0);
  endtask

  task automatic test_mixed();
    a_data[2] = 8'hFD; a_valid[2] = 1'b1; b_valid[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({rdy0[2], rdy1[2]} !== 2'b00) begin
        fails++; $display("FAIL lone_valid cyc=%0d rdy=%b exp=00", i, {rdy0[2], rdy1[2]});
      end
    end
    @(posedge clk); #1;
    do_op(2, 8'hFD, 8'd200, 0, 1'b0);
    do_op(2, 8'h80, 8'd255, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_op(0, 8'd12, 8'd10, 5, 1'b1);
    do_op(0, 8'd3, 8'd5, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int stale;
    a_data[0] = 8'd9; b_data[0] = 8'd9; a_valid[0] = 1'b1; b_valid[0] = 1'b1;
    @(posedge clk); #1;
    a_valid[0] = 1'b0; b_valid[0] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    tests++;
    if (o_valid[0] !== 1'b0 || o_data[0] !== '0) begin
      fails++; $display("FAIL reset_mid valid=%b data=%h exp=0/0000", o_valid[0], o_data[0]);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_valid[0] !== 1'b0) stale++;
    end
    tests++;
    if (stale != 0) begin
      fails++; $display("FAIL stale_output got=%0d valid cycles exp=0", stale);
    end
    @(posedge clk); #1;
    do_op(0, 8'd7, 8'd6, 0, 1'b0);
  endtask

  task automatic test_early_term();
    do_op(0, 8'd200, 8'd1, 0, 1'b0);
    do_op(0, 8'd99, 8'd0, 0, 1'b0);
    do_op(1, 8'h81, 8'hFE, 0, 1'b0);
    do_op(2, 8'h90, 8'd16, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 18; k++) begin
      do_op(k % 3, T0'($urandom), T1'($urandom), int'($urandom_range(0, 2)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_mixed();
    test_backpressure();
    test_reset_mid();
    test_early_term();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
